// File: rtl/calc_pkg.sv
// Shared definitions for the scan calculator: operator codes, FSM states and
// active-low 7-segment glyphs ({dp,g,f,e,d,c,b,a}).
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_CONV,
        ST_DONE
    } state_t;

    localparam logic [7:0] FONT_0     = 8'hC0;
    localparam logic [7:0] FONT_1     = 8'hF9;
    localparam logic [7:0] FONT_2     = 8'hA4;
    localparam logic [7:0] FONT_3     = 8'hB0;
    localparam logic [7:0] FONT_4     = 8'h99;
    localparam logic [7:0] FONT_5     = 8'h92;
    localparam logic [7:0] FONT_6     = 8'h82;
    localparam logic [7:0] FONT_7     = 8'hF8;
    localparam logic [7:0] FONT_8     = 8'h80;
    localparam logic [7:0] FONT_9     = 8'h90;
    localparam logic [7:0] FONT_BLANK = 8'hFF;
    localparam logic [7:0] FONT_MINUS = 8'hBF;

    function automatic logic [7:0] font_of(input logic [3:0] d);
        case (d)
            4'd0:    font_of = FONT_0;
            4'd1:    font_of = FONT_1;
            4'd2:    font_of = FONT_2;
            4'd3:    font_of = FONT_3;
            4'd4:    font_of = FONT_4;
            4'd5:    font_of = FONT_5;
            4'd6:    font_of = FONT_6;
            4'd7:    font_of = FONT_7;
            4'd8:    font_of = FONT_8;
            4'd9:    font_of = FONT_9;
            default: font_of = FONT_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: start loads and performs the first shift,
// done pulses IN_W cycles later; ovf flags a value needing more than DIGITS digits.
module bin2bcd_seq #(
    parameter int IN_W   = 16,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd,
    output logic                  ovf
);

    localparam int BCD_D = ((IN_W + 2) / 3 > DIGITS) ? (IN_W + 2) / 3 : DIGITS;
    localparam int CW    = $clog2(IN_W + 1);

    logic [IN_W-1:0]    bin_reg;
    logic [BCD_D*4-1:0] bcd_reg;
    logic [BCD_D*4-1:0] bcd_adj;
    logic [CW-1:0]      cnt_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               ovf_c;

    genvar gi;
    generate
        for (gi = 0; gi < BCD_D; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            bin_reg  <= '0;
            bcd_reg  <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                // First iteration folded into the load: adjusting an all-zero BCD is a no-op.
                bin_reg  <= bin << 1;
                bcd_reg  <= {{(BCD_D*4-1){1'b0}}, bin[IN_W-1]};
                cnt_reg  <= CW'(IN_W - 1);
                busy_reg <= 1'b1;
            end else if (busy_reg) begin
                {bcd_reg, bin_reg} <= {bcd_adj, bin_reg} << 1;
                cnt_reg <= cnt_reg - 1'b1;
                if (cnt_reg == CW'(1)) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        ovf_c = 1'b0;
        for (int i = DIGITS; i < BCD_D; i++) begin
            ovf_c = ovf_c | (bcd_reg[i*4 +: 4] != 4'd0);
        end
    end

    assign done = done_reg;
    assign bcd  = bcd_reg[DIGITS*4-1:0];
    assign ovf  = ovf_c;

endmodule

// File: rtl/scan_calculator.sv
// Sequential add/sub/mul calculator with BCD conversion and a multiplexed FND driver.
// Define CALC_DIV_EN to build the restoring divider for operator 11.
module scan_calculator
    import calc_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  i_A,
    input  logic [WIDTH-1:0]  i_B,
    input  logic [1:0]        i_selOperator,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_neg,
    output logic              o_err,
    output logic [DIGITS-1:0] o_digit,
    output logic [7:0]        o_fndfont
);

    localparam int RW    = 2 * WIDTH;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SC_W  = $clog2(SCAN_DIV);

    state_t              state_reg, state_next;
    logic [WIDTH-1:0]    a_reg, b_reg;
    logic [1:0]          op_reg;
    logic                neg_reg, err_reg;
    logic [RW-1:0]       calc_value;
    logic                bcd_start, bcd_done, bcd_ovf, neg_nofit;
    logic [DIGITS*4-1:0] bcd_val;
    logic [DIGITS*4-1:0] disp_bcd_reg;
    logic                disp_neg_reg, disp_err_reg;

`ifdef CALC_DIV_EN
    localparam int DCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    logic [WIDTH-1:0] q_reg, rem_reg, q_next;
    logic [WIDTH:0]   rem_shift;
    logic [DCW-1:0]   div_cnt_reg;
    logic             rem_ge, div_last;

    assign rem_shift = {rem_reg, q_reg[WIDTH-1]};
    assign rem_ge    = rem_shift >= {1'b0, b_reg};
    assign q_next    = {q_reg[WIDTH-2:0], rem_ge};
    assign div_last  = div_cnt_reg == DCW'(WIDTH - 1);
`endif

    bin2bcd_seq #(.IN_W(RW), .DIGITS(DIGITS)) u_bcd (
        .clk   (clk),
        .srst  (reset),
        .start (bcd_start),
        .bin   (calc_value),
        .done  (bcd_done),
        .bcd   (bcd_val),
        .ovf   (bcd_ovf)
    );

    always_comb begin
        state_next = state_reg;
        bcd_start  = 1'b0;
        calc_value = '0;
        case (state_reg)
            ST_IDLE: if (i_start) state_next = ST_CALC;
            ST_CALC: begin
                case (op_reg)
                    OP_ADD: calc_value = RW'(a_reg) + RW'(b_reg);
                    OP_SUB: calc_value = (a_reg >= b_reg) ? RW'(a_reg - b_reg) : RW'(b_reg - a_reg);
                    OP_MUL: calc_value = RW'(a_reg) * RW'(b_reg);
                    default: calc_value = '0;
                endcase
                if (op_reg != OP_DIV) begin
                    bcd_start  = 1'b1;
                    state_next = ST_CONV;
                end else begin
`ifdef CALC_DIV_EN
                    if (div_last) begin
                        if (b_reg == '0) begin
                            state_next = ST_DONE;
                        end else begin
                            // Final quotient bit is formed this cycle; feed it straight in.
                            calc_value = RW'(q_next);
                            bcd_start  = 1'b1;
                            state_next = ST_CONV;
                        end
                    end
`else
                    state_next = ST_DONE;
`endif
                end
            end
            ST_CONV: if (bcd_done) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // A negative result needs a free digit above its most significant digit.
    assign neg_nofit = neg_reg && (bcd_val[DIGITS*4-1 -: 4] != 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            a_reg        <= '0;
            b_reg        <= '0;
            op_reg       <= OP_ADD;
            neg_reg      <= 1'b0;
            err_reg      <= 1'b0;
            disp_bcd_reg <= '0;
            disp_neg_reg <= 1'b0;
            disp_err_reg <= 1'b0;
`ifdef CALC_DIV_EN
            q_reg        <= '0;
            rem_reg      <= '0;
            div_cnt_reg  <= '0;
`endif
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: if (i_start) begin
                    a_reg   <= i_A;
                    b_reg   <= i_B;
                    op_reg  <= i_selOperator;
                    neg_reg <= 1'b0;
                    err_reg <= 1'b0;
`ifdef CALC_DIV_EN
                    q_reg       <= i_A;
                    rem_reg     <= '0;
                    div_cnt_reg <= '0;
`endif
                end
                ST_CALC: begin
                    if (op_reg == OP_SUB && a_reg < b_reg) neg_reg <= 1'b1;
                    if (op_reg == OP_DIV) begin
`ifdef CALC_DIV_EN
                        q_reg       <= q_next;
                        rem_reg     <= rem_ge ? WIDTH'(rem_shift - {1'b0, b_reg}) : rem_shift[WIDTH-1:0];
                        div_cnt_reg <= div_cnt_reg + 1'b1;
                        if (div_last && b_reg == '0) err_reg <= 1'b1;
`else
                        err_reg <= 1'b1;
`endif
                    end
                end
                ST_CONV: if (bcd_done && bcd_ovf) err_reg <= 1'b1;
                ST_DONE: begin
                    disp_bcd_reg <= bcd_val;
                    disp_err_reg <= err_reg | neg_nofit;
                    disp_neg_reg <= neg_reg & ~neg_nofit & ~err_reg;
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (state_reg == ST_CALC) || (state_reg == ST_CONV);
    assign o_done = (state_reg == ST_DONE);
    assign o_neg  = disp_neg_reg;
    assign o_err  = disp_err_reg;

    logic [SC_W-1:0]   scan_cnt_reg;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [DIGITS-1:0] digit_reg;
    logic [7:0]        font_reg, glyph;
    logic              wrap;
    int                msd, sel;

    assign wrap = scan_cnt_reg == SC_W'(SCAN_DIV - 1);

    always_comb begin
        idx_next = idx_reg;
        if (wrap) idx_next = (idx_reg == IDX_W'(DIGITS - 1)) ? '0 : idx_reg + 1'b1;
    end

    always_comb begin
        msd = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (disp_bcd_reg[i*4 +: 4] != 4'd0) msd = i;
        end
        sel   = int'(idx_next);
        glyph = FONT_BLANK;
        if (disp_err_reg)                         glyph = FONT_MINUS;
        else if (sel <= msd)                      glyph = font_of(disp_bcd_reg[sel*4 +: 4]);
        else if (disp_neg_reg && sel == msd + 1)  glyph = FONT_MINUS;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt_reg <= '0;
            idx_reg      <= '0;
            digit_reg    <= ~DIGITS'(1);
            font_reg     <= FONT_0;
        end else begin
            scan_cnt_reg <= wrap ? '0 : scan_cnt_reg + 1'b1;
            idx_reg      <= idx_next;
            digit_reg    <= ~(DIGITS'(1) << idx_next);
            font_reg     <= glyph;
        end
    end

    assign o_digit   = digit_reg;
    assign o_fndfont = font_reg;

endmodule

// File: tb/tb_scan_calculator.sv
// Directed scoreboard bench for scan_calculator (WIDTH=8, DIGITS=4, SCAN_DIV=4);
// honours CALC_DIV_EN when deciding the expected divide behaviour.
module tb_scan_calculator;

    localparam int WIDTH    = 8;
    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] i_A = '0;
    logic [WIDTH-1:0] i_B = '0;
    logic [1:0]       i_selOperator = 2'b00;
    logic             i_start = 1'b0;
    logic             o_busy, o_done, o_neg, o_err;
    logic [DIGITS-1:0] o_digit;
    logic [7:0]       o_fndfont;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          lat;
        bit          neg;
        bit          err;
        logic [31:0] fonts;
    } exp_t;

    exp_t sb[$];

    scan_calculator #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_A           (i_A),
        .i_B           (i_B),
        .i_selOperator (i_selOperator),
        .i_start       (i_start),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_neg         (o_neg),
        .o_err         (o_err),
        .o_digit       (o_digit),
        .o_fndfont     (o_fndfont)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] seg(input int d);
        case (d)
            0: seg = 8'hC0;  1: seg = 8'hF9;  2: seg = 8'hA4;  3: seg = 8'hB0;
            4: seg = 8'h99;  5: seg = 8'h92;  6: seg = 8'h82;  7: seg = 8'hF8;
            8: seg = 8'h80;  9: seg = 8'h90;  default: seg = 8'hFF;
        endcase
    endfunction

    function automatic exp_t model(input int a, input int b, input int op);
        exp_t e;
        int   mag, msd;
        int   d[4];
        e.neg = 1'b0; e.err = 1'b0; e.lat = 19; mag = 0;
        case (op)
            0: mag = a + b;
            1: if (a >= b) mag = a - b; else begin mag = b - a; e.neg = 1'b1; end
            2: mag = a * b;
            default: begin
`ifdef CALC_DIV_EN
                if (b == 0) begin e.err = 1'b1; e.lat = 10; end
                else begin mag = a / b; e.lat = 26; end
`else
                e.err = 1'b1; e.lat = 3;
`endif
            end
        endcase
        if (mag > 9999) e.err = 1'b1;
        msd = 0;
        for (int i = 0; i < 4; i++) begin
            d[i] = (mag / (10 ** i)) % 10;
            if (d[i] != 0) msd = i;
        end
        if (e.neg && msd == 3) e.err = 1'b1;
        if (e.err) e.neg = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (e.err)                       e.fonts[i*8 +: 8] = 8'hBF;
            else if (i <= msd)               e.fonts[i*8 +: 8] = seg(d[i]);
            else if (e.neg && i == msd + 1)  e.fonts[i*8 +: 8] = 8'hBF;
            else                             e.fonts[i*8 +: 8] = 8'hFF;
        end
        return e;
    endfunction

    // One full scan rotation; ok drops on a bad select pattern or stray busy/done.
    task automatic collect(output logic [31:0] f, output bit ok);
        f = '0;
        ok = 1'b1;
        for (int k = 0; k < DIGITS * SCAN_DIV; k++) begin
            @(negedge clk);
            if (o_busy || o_done) ok = 1'b0;
            case (o_digit)
                4'b1110: f[7:0]   = o_fndfont;
                4'b1101: f[15:8]  = o_fndfont;
                4'b1011: f[23:16] = o_fndfont;
                4'b0111: f[31:24] = o_fndfont;
                default: ok = 1'b0;
            endcase
        end
    endtask

    task automatic run_op(input int a, input int b, input int op, input int inject);
        exp_t        e;
        int          lat;
        logic [31:0] f;
        bit          ok;
        sb.push_back(model(a, b, op));
        @(negedge clk);
        i_A = a[WIDTH-1:0];
        i_B = b[WIDTH-1:0];
        i_selOperator = op[1:0];
        i_start = 1'b1;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) chk("busy_after_start", 32'(o_busy), 32'd1);
            i_start = (k == inject);
            i_A = WIDTH'($urandom_range(0, 255));
            i_B = WIDTH'($urandom_range(0, 255));
            if (o_done) begin
                lat = k + 1;
                break;
            end
        end
        i_start = 1'b0;
        e = sb.pop_front();
        chk("latency", 32'(lat), 32'(e.lat));
        chk("busy_at_done", 32'(o_busy), 32'd0);
        repeat (2) @(negedge clk);
        chk("neg", 32'(o_neg), 32'(e.neg));
        chk("err", 32'(o_err), 32'(e.err));
        collect(f, ok);
        chk("fonts", f, e.fonts);
        chk("scan_ok", 32'(ok), 32'd1);
        $display("op a=%0d b=%0d op=%0d lat=%0d neg=%0b err=%0b fonts=%h", a, b, op, lat, o_neg, o_err, f);
    endtask

    initial begin
        logic [31:0] f;
        bit          ok;
        int          seen;
        logic [3:0]  ed;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_neg", 32'(o_neg), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_digit", 32'(o_digit), 32'h0000000E);
        chk("rst_font", 32'(o_fndfont), 32'h000000C0);
        reset = 1'b0;
        for (int step = 1; step <= 16; step++) begin
            @(negedge clk);
            ed = ~(4'b0001 << ((step / 4) % 4));
            chk("digit_walk", 32'(o_digit), 32'(ed));
        end
        $display("reset/walk done");

        run_op(12, 34, 0, 0);
        run_op(5, 9, 1, 0);
        run_op(200, 200, 2, 0);

        // Abandon a multiply mid-conversion with reset.
        @(negedge clk);
        i_A = 8'd200; i_B = 8'd200; i_selOperator = 2'b10; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("busy_after_abort", 32'(o_busy), 32'd0);
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (o_done) seen++;
        end
        chk("no_done_after_abort", 32'(seen), 32'd0);
        chk("err_after_abort", 32'(o_err), 32'd0);
        collect(f, ok);
        chk("fonts_after_abort", f, 32'hFFFFFFC0);
        chk("scan_ok_after_abort", 32'(ok), 32'd1);
        $display("abort seen_done=%0d fonts=%h", seen, f);

        run_op(255, 7, 3, 0);
        run_op(9, 0, 3, 0);
        run_op(200, 3, 1, 0);
        run_op(99, 1, 0, 5);
        run_op(99, 99, 2, 0);
        run_op(7, 7, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
